// File: rtl/axi_mst_initiator.sv
// AXI3-style master traffic generator: one burst per command on AW+W or AR, with B/R checking.
// Optional build macro AXI_MST_RAND_READY_EN drives bready/rready from a 16-bit LFSR.
module axi_mst_initiator #(
  parameter int unsigned AXI_ADDR_W   = 32,
  parameter int unsigned AXI_ID_W     = 4,
  parameter int unsigned AXI_DATA_W   = 32,
  parameter int unsigned MST_OSTD_NUM = 4,
  parameter logic [31:0] DATA_SEED    = 32'h1000_0000
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [AXI_ADDR_W-1:0]   cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [AXI_ID_W-1:0]     cmd_id,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [AXI_ADDR_W-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [AXI_ID_W-1:0]     awid,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [AXI_DATA_W-1:0]   wdata,
  output logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    wlast,
  output logic [AXI_ID_W-1:0]     wid,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [AXI_ID_W-1:0]     bid,
  input  logic [1:0]              bresp,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [AXI_ADDR_W-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [AXI_ID_W-1:0]     arid,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [AXI_ID_W-1:0]     rid,
  input  logic [AXI_DATA_W-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  output logic                    wr_done,
  output logic                    rd_done,
  output logic [15:0]             err_cnt
);

  localparam int unsigned STRB_W = AXI_DATA_W / 8;
  localparam int unsigned SIZE   = $clog2(STRB_W);
  localparam int unsigned PTR_W  = $clog2(MST_OSTD_NUM);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] OSTD = CNT_W'(MST_OSTD_NUM);

  typedef enum logic [1:0] {WIDLE, WADDR, WDATA} w_state_t;
  typedef enum logic       {RIDLE, RADDR}        r_state_t;

  w_state_t            w_state;
  r_state_t            r_state;
  logic                rst_done;
  logic [3:0]          w_beat;
  logic [3:0]          w_beat_nxt;
  logic [3:0]          r_beat;
  logic [CNT_W-1:0]    w_cnt, r_cnt;
  logic [PTR_W-1:0]    w_wptr, w_rptr, r_wptr, r_rptr;
  logic [AXI_ID_W-1:0] w_fifo_id  [MST_OSTD_NUM];
  logic [AXI_ID_W-1:0] r_fifo_id  [MST_OSTD_NUM];
  logic [3:0]          r_fifo_len [MST_OSTD_NUM];

  logic cmd_hs, wcmd_hs, rcmd_hs, aw_hs, ar_hs, b_hs, r_hs;
  logic w_empty, r_empty, b_pop, r_at_len, r_close;
  logic [2:0]  b_err, r_err, err_add;
  logic [16:0] err_sum;
  logic        unused_rdata;

  assign awsize  = 3'(SIZE);
  assign arsize  = 3'(SIZE);
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wstrb   = '1;
  assign unused_rdata = ^rdata;

  // Ready is steered by the command type so a read never waits on the write side
  assign cmd_ready = rst_done && (cmd_wr ? (w_state == WIDLE && w_cnt < OSTD)
                                         : (r_state == RIDLE && r_cnt < OSTD));

  assign cmd_hs     = cmd_valid && cmd_ready;
  assign wcmd_hs    = cmd_hs && cmd_wr;
  assign rcmd_hs    = cmd_hs && !cmd_wr;
  assign aw_hs      = awvalid && awready;
  assign ar_hs      = arvalid && arready;
  assign b_hs       = bvalid && bready;
  assign r_hs       = rvalid && rready;
  assign w_empty    = (w_cnt == '0);
  assign r_empty    = (r_cnt == '0);
  assign b_pop      = b_hs && !w_empty;
  assign r_at_len   = (r_beat == r_fifo_len[r_rptr]);
  assign r_close    = r_hs && !r_empty && (rlast || r_at_len);
  assign w_beat_nxt = w_beat + 4'd1;

  function automatic logic [AXI_DATA_W-1:0] pattern(input logic [AXI_ID_W-1:0] id,
                                                    input logic [3:0] beat);
    return AXI_DATA_W'(DATA_SEED) + AXI_DATA_W'({id, beat});
  endfunction

  // Per-handshake error contributions; several faults on one beat add up
  always_comb begin
    b_err = 3'd0;
    r_err = 3'd0;
    if (b_hs) begin
      if (w_empty) b_err = 3'd1;
      else         b_err = 3'(bid != w_fifo_id[w_rptr]) + 3'(bresp != 2'b00);
    end
    if (r_hs) begin
      if (r_empty) r_err = 3'd1;
      else         r_err = 3'(rlast != r_at_len) + 3'(rid != r_fifo_id[r_rptr])
                         + 3'(rresp != 2'b00);
    end
    err_add = b_err + r_err;
    err_sum = {1'b0, err_cnt} + 17'(err_add);
  end

  // Write FSM: AW first, then the W burst with a seeded data pattern
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= WIDLE;
      awvalid <= 1'b0;
      awaddr  <= '0;
      awlen   <= 4'd0;
      awid    <= '0;
      wvalid  <= 1'b0;
      wdata   <= '0;
      wlast   <= 1'b0;
      wid     <= '0;
      w_beat  <= 4'd0;
    end else begin
      case (w_state)
        WIDLE: if (wcmd_hs) begin
          awaddr  <= cmd_addr;
          awlen   <= cmd_len;
          awid    <= cmd_id;
          wid     <= cmd_id;
          awvalid <= 1'b1;
          w_state <= WADDR;
        end
        WADDR: if (awready) begin
          awvalid <= 1'b0;
          wvalid  <= 1'b1;
          w_beat  <= 4'd0;
          wdata   <= pattern(awid, 4'd0);
          wlast   <= (awlen == 4'd0);
          w_state <= WDATA;
        end
        WDATA: if (wready) begin
          if (wlast) begin
            wvalid  <= 1'b0;
            wlast   <= 1'b0;
            w_state <= WIDLE;
          end else begin
            w_beat <= w_beat_nxt;
            wdata  <= pattern(wid, w_beat_nxt);
            wlast  <= (w_beat_nxt == awlen);
          end
        end
        default: w_state <= WIDLE;
      endcase
    end
  end

  // Read FSM: single AR per command
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= RIDLE;
      arvalid <= 1'b0;
      araddr  <= '0;
      arlen   <= 4'd0;
      arid    <= '0;
    end else begin
      case (r_state)
        RIDLE: if (rcmd_hs) begin
          araddr  <= cmd_addr;
          arlen   <= cmd_len;
          arid    <= cmd_id;
          arvalid <= 1'b1;
          r_state <= RADDR;
        end
        RADDR: if (arready) begin
          arvalid <= 1'b0;
          r_state <= RIDLE;
        end
      endcase
    end
  end

  // Tracking FIFO storage; occupancy lives in the counters
  always_ff @(posedge aclk) begin
    if (aw_hs) w_fifo_id[w_wptr] <= awid;
    if (ar_hs) begin
      r_fifo_id[r_wptr]  <= arid;
      r_fifo_len[r_wptr] <= arlen;
    end
  end

  // Outstanding counts, pointers, R beat tracking, completion pulses and errors
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done <= 1'b0;
      w_cnt    <= '0;
      r_cnt    <= '0;
      w_wptr   <= '0;
      w_rptr   <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_beat   <= 4'd0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      err_cnt  <= 16'd0;
    end else begin
      rst_done <= 1'b1;
      w_cnt    <= w_cnt + CNT_W'(aw_hs) - CNT_W'(b_pop);
      r_cnt    <= r_cnt + CNT_W'(ar_hs) - CNT_W'(r_close);
      if (aw_hs)   w_wptr <= w_wptr + PTR_W'(1);
      if (b_pop)   w_rptr <= w_rptr + PTR_W'(1);
      if (ar_hs)   r_wptr <= r_wptr + PTR_W'(1);
      if (r_close) r_rptr <= r_rptr + PTR_W'(1);
      if (r_hs) begin
        if (r_close || rlast) r_beat <= 4'd0;
        else                  r_beat <= r_beat + 4'd1;
      end
      wr_done <= b_hs;
      rd_done <= r_hs && rlast;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

`ifdef AXI_MST_RAND_READY_EN
  // Free-running LFSR (x^16+x^14+x^13+x^11) throttles the response channels
  logic [15:0] lfsr;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr   <= 16'hACE1;
      bready <= 1'b0;
      rready <= 1'b0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      bready <= lfsr[0];
      rready <= lfsr[8];
    end
  end
`else
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bready <= 1'b0;
      rready <= 1'b0;
    end else begin
      bready <= 1'b1;
      rready <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_mst_initiator.sv
// Scoreboard bench for axi_mst_initiator: directed commands push expected AW/W/AR beats and
// completion error counts; a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi_mst_initiator;

  localparam logic [31:0] SEED = 32'h1000_0000;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len, cmd_id;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awlen, awid;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        wvalid, wready, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb, wid;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arlen, arid;
  logic        rvalid, rready, rlast;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        wr_done, rd_done;
  logic [15:0] err_cnt;

  logic [3:0]  b_id_xor;
  logic [1:0]  b_resp_val;

  int n_checks = 0;
  int n_errors = 0;
  int w_seen   = 0;

  logic [39:0] exp_aw [$];
  logic [36:0] exp_w  [$];
  logic [39:0] exp_ar [$];
  logic [15:0] exp_wr [$];
  logic [15:0] exp_rd [$];

  axi_mst_initiator dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wid(wid),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast),
    .wr_done(wr_done), .rd_done(rd_done), .err_cnt(err_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: expected event did not occur in time", name);
  endtask

  task automatic flush_exp();
    exp_aw.delete();
    exp_w.delete();
    exp_ar.delete();
    exp_wr.delete();
    exp_rd.delete();
  endtask

  // Present one command, push its expected channel traffic, wait for acceptance
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] id, input logic [15:0] err_after);
    bit ok;
    ok = 1'b0;
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    if (wr) begin
      exp_aw.push_back({addr, len, id});
      for (int b = 0; b <= int'(len); b++)
        exp_w.push_back({SEED + {24'd0, id, 4'(b)}, (4'(b) == len), id});
      exp_wr.push_back(err_after);
    end else begin
      exp_ar.push_back({addr, len, id});
      exp_rd.push_back(err_after);
    end
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("cmd_accept");
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  // Return nbeats R beats for one ID, rlast on the final one
  task automatic send_r(input logic [3:0] id, input int nbeats);
    bit got;
    for (int b = 0; b < nbeats; b++) begin
      got = 1'b0;
      @(posedge aclk); #1;
      rvalid = 1'b1; rid = id; rresp = 2'b00;
      rdata = {24'd0, id, 4'(b)}; rlast = (b == nbeats - 1);
      for (int t = 0; t < 50; t++) begin
        @(negedge aclk);
        if (rready) begin got = 1'b1; break; end
      end
      if (!got) fail_now("r_ready");
    end
    @(posedge aclk); #1;
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge aclk);
      if (exp_aw.size() == 0 && exp_w.size() == 0 && exp_ar.size() == 0 &&
          exp_wr.size() == 0 && exp_rd.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail_now({name, "_drain"});
      flush_exp();
    end
  endtask

  // Monitor: handshakes about to complete, hold stability, completion pulses
  logic        aw_stall, w_stall;
  logic [39:0] aw_prev;
  logic [36:0] w_prev;
  initial begin
    aw_stall = 1'b0; w_stall = 1'b0; aw_prev = '0; w_prev = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        aw_stall = 1'b0;
        w_stall  = 1'b0;
      end else begin
        if (aw_stall) chk("aw_hold", {awvalid, awaddr, awlen, awid}, {1'b1, aw_prev});
        if (w_stall)  chk("w_hold", {wvalid, wdata, wlast, wid}, {1'b1, w_prev});
        aw_stall = awvalid && !awready;
        aw_prev  = {awaddr, awlen, awid};
        w_stall  = wvalid && !wready;
        w_prev   = {wdata, wlast, wid};
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) fail_now("aw_unexpected");
          else chk("aw", {awaddr, awlen, awid}, exp_aw.pop_front());
        end
        if (wvalid && wready) begin
          w_seen++;
          if (exp_w.size() == 0) fail_now("w_unexpected");
          else chk("w", {wdata, wlast, wid}, exp_w.pop_front());
        end
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) fail_now("ar_unexpected");
          else chk("ar", {araddr, arlen, arid}, exp_ar.pop_front());
        end
        if (wr_done) begin
          if (exp_wr.size() == 0) fail_now("wr_done_unexpected");
          else chk("wr_done_err", err_cnt, exp_wr.pop_front());
        end
        if (rd_done) begin
          if (exp_rd.size() == 0) fail_now("rd_done_unexpected");
          else chk("rd_done_err", err_cnt, exp_rd.pop_front());
        end
      end
    end
  end

  // B responder: one response per completed W burst, with optional corruption
  logic       b_fire;
  logic [3:0] b_q [$];
  initial begin
    bvalid = 1'b0; bid = '0; bresp = 2'b00; b_fire = 1'b0;
    forever begin
      @(negedge aclk);
      b_fire = bvalid && bready;
      if (!aresetn) b_q.delete();
      else if (wvalid && wready && wlast) b_q.push_back(wid);
      @(posedge aclk); #1;
      if (!aresetn) bvalid = 1'b0;
      else begin
        if (b_fire) bvalid = 1'b0;
        if (!bvalid && b_q.size() > 0) begin
          bid    = b_q.pop_front() ^ b_id_xor;
          bresp  = b_resp_val;
          bvalid = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int w0;
    aresetn = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    b_id_xor = 4'h0; b_resp_val = 2'b00;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_outputs", {awvalid, wvalid, wlast, arvalid, cmd_ready, bready, rready,
                        wr_done, rd_done}, 9'd0);
    chk("rst_err_cnt", err_cnt, 16'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    chk("ready_after_rst", {bready, rready}, 2'b11);
    chk("fixed_fields", {awsize, awburst, arsize, arburst, wstrb},
        {3'd2, 2'b01, 3'd2, 2'b01, 4'hF});

    // Plain write burst, id 5, 4 beats
    issue_cmd(1'b1, 32'h100, 4'd3, 4'd5, 16'd0);
    wait_drain("t1");
    chk("t1_err_cnt", err_cnt, 16'd0);

    // Fill the read tracker, then a fifth read must wait for the first rlast
    issue_cmd(1'b0, 32'h1000, 4'd0,  4'd1, 16'd0);
    issue_cmd(1'b0, 32'h2000, 4'd1,  4'd2, 16'd0);
    issue_cmd(1'b0, 32'h3000, 4'd2,  4'd3, 16'd0);
    issue_cmd(1'b0, 32'h4000, 4'd15, 4'd4, 16'd0);
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h5000; cmd_len = 4'd0; cmd_id = 4'd6;
    exp_ar.push_back({32'h5000, 4'd0, 4'd6});
    exp_rd.push_back(16'd0);
    repeat (3) begin
      @(negedge aclk);
      chk("t2_full_cmd_ready", cmd_ready, 1'b0);
    end
    fork
      begin
        send_r(4'd1, 1); send_r(4'd2, 2); send_r(4'd3, 3); send_r(4'd4, 16);
      end
      begin
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(negedge aclk);
          if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("t2_accept");
        else chk("t2_accept_at_rlast", rd_done, 1'b1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
      end
    join
    send_r(4'd6, 1);
    wait_drain("t2");
    chk("t2_err_cnt", err_cnt, 16'd0);

    // AW and W backpressure: payload held, beat count unchanged
    w0 = w_seen;
    awready = 1'b0; wready = 1'b0;
    issue_cmd(1'b1, 32'h200, 4'd2, 4'd3, 16'd0);
    repeat (5) @(negedge aclk);
    @(posedge aclk); #1;
    awready = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge aclk);
      if (wvalid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("t3_wvalid");
    repeat (5) @(negedge aclk);
    @(posedge aclk); #1;
    wready = 1'b1;
    wait_drain("t3");
    chk("t3_w_beats", 32'(w_seen - w0), 32'd3);

    // Early rlast on beat 1 of a 4-beat read, then a clean read
    issue_cmd(1'b0, 32'h600, 4'd3, 4'd7, 16'd1);
    send_r(4'd7, 2);
    wait_drain("t4a");
    issue_cmd(1'b0, 32'h700, 4'd1, 4'd8, 16'd1);
    send_r(4'd8, 2);
    wait_drain("t4b");
    chk("t4_err_cnt", err_cnt, 16'd1);

    // SLVERR plus wrong BID on one response
    b_id_xor = 4'hF; b_resp_val = 2'b10;
    issue_cmd(1'b1, 32'h300, 4'd0, 4'd2, 16'd3);
    wait_drain("t5");
    b_id_xor = 4'h0; b_resp_val = 2'b00;
    chk("t5_err_cnt", err_cnt, 16'd3);

    // Asynchronous reset during W beat 2 of an 8-beat write
    issue_cmd(1'b1, 32'h800, 4'd7, 4'd9, 16'd3);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge aclk);
      if (wvalid && wdata == SEED + 32'h92) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("t6_beat2");
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_mid_rst_outputs", {awvalid, wvalid, wlast, arvalid, cmd_ready, bready, rready},
        7'd0);
    chk("t6_mid_rst_err_cnt", err_cnt, 16'd0);
    flush_exp();
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    issue_cmd(1'b1, 32'h900, 4'd1, 4'd4, 16'd0);
    wait_drain("t6");
    chk("t6_err_cnt", err_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
